// File: rtl/i2c_cmd_arbiter_if.sv
// Bundle between NREQ command requesters, the command arbiter and the I2C write master.
// slave is the arbiter's view; master is the view of the requesters and the I2C engine.
interface i2c_cmd_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [24*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 busy;
    logic                 mgo;
    logic [23:0]          i2c_data;
    logic                 mend;
    logic                 mack;

    modport slave (
        input  req, req_data, mend, mack,
        output grant, done, err, busy, mgo, i2c_data
    );

    modport master (
        output req, req_data, mend, mack,
        input  grant, done, err, busy, mgo, i2c_data
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin share of one I2C write master with NACK retry and idle gap; I2C_ARB_TIMEOUT_EN adds an XFER watchdog.
// Latency: grant 1 cycle after req is sampled in IDLE, mgo 1 cycle later, done/err 1 cycle after mend.
// Backpressure: requesters hold req until done/err; XFER waits on mend (bounded only with the watchdog).
module i2c_cmd_arbiter #(
    parameter int NREQ           = 2,
    parameter int RETRY_MAX      = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    i2c_cmd_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, XFER, GAP} state_t;

    state_t          state;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic            mgo;
    logic            busy;
    logic [23:0]     i2c_data;
    logic [IW-1:0]   last;
    logic [RW-1:0]   retry;
    logic [GW-1:0]   gap_cnt;
    logic            final_gap;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_mask;
    logic [23:0]     win_data;
    int              win;
    int              cand;

    // Scan from farthest to nearest so the first set bit after 'last' is the final assignment.
    always_comb begin
        win     = 0;
        cand    = 0;
        win_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (bus.req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
        win_idx  = IW'(win);
        win_mask = NREQ'(1) << win_idx;
        win_data = bus.req_data[24*win +: 24];
    end

    logic tmo_hit;
    logic xfer_end;
    logic xfer_ack;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit has no effect.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
`endif

    // A real mend always takes precedence over a watchdog expiry in the same cycle.
    assign xfer_end = bus.mend | tmo_hit;
    assign xfer_ack = bus.mend & bus.mack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            mgo       <= 1'b0;
            busy      <= 1'b0;
            i2c_data  <= '0;
            last      <= IW'(NREQ - 1);
            retry     <= '0;
            gap_cnt   <= '0;
            final_gap <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant    <= win_mask;
                        i2c_data <= win_data;
                        last     <= win_idx;
                        retry    <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    mgo   <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= XFER;
                end
                XFER: begin
                    if (xfer_end) begin
                        mgo     <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                        if (xfer_ack) begin
                            done      <= grant;
                            final_gap <= 1'b1;
                        end else if (retry != RW'(RETRY_MAX)) begin
                            retry     <= retry + RW'(1);
                            final_gap <= 1'b0;
                        end else begin
                            err       <= grant;
                            final_gap <= 1'b1;
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        if (final_gap) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant;
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.mgo      = mgo;
    assign bus.busy     = busy;
    assign bus.i2c_data = i2c_data;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: an event-schedule model checked every cycle plus literal expectations per scenario.
module tb_i2c_cmd_arbiter;
    localparam int NREQ           = 2;
    localparam int RETRY_MAX      = 3;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 100;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    i2c_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_cmd_arbiter #(
        .NREQ(NREQ), .RETRY_MAX(RETRY_MAX), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    endtask

    // I2C master model: answers each mgo after dly cycles unless hung.
    int dly        = 20;
    int ack_mode   = 1;   // 0: always NACK, 1: always ACK, 2: NACK first attempt then ACK
    bit hang       = 1'b0;
    int att_total  = 0;
    int att_base   = 0;
    int hi_cnt     = 0;
    bit responded  = 1'b0;

    function automatic logic ack_now();
        if (ack_mode == 1) return 1'b1;
        if (ack_mode == 2) return (att_total - att_base) >= 1;
        return 1'b0;
    endfunction

    initial begin
        bus.mend = 1'b0;
        bus.mack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                bus.mend = 1'b0; bus.mack = 1'b0; hi_cnt = 0; responded = 1'b0;
            end else if (bus.mend) begin
                bus.mend = 1'b0; bus.mack = 1'b0;
            end else if (!bus.mgo) begin
                hi_cnt = 0; responded = 1'b0;
            end else if (!hang && !responded) begin
                hi_cnt++;
                if (hi_cnt >= dly) begin
                    bus.mend = 1'b1; bus.mack = ack_now(); att_total++; responded = 1'b1;
                end
            end
        end
    end

    // Model: expected outputs after each edge, driven by a schedule of edge numbers.
    int              md_owner, md_last, md_tries;
    longint          md_rise_at, md_release_at, md_rose_at;
    logic [NREQ-1:0] e_grant, e_done, e_err;
    logic            e_mgo, e_busy;
    logic [23:0]     e_data;

    task automatic model_reset();
        md_owner = -1; md_last = NREQ - 1; md_tries = 0;
        md_rise_at = -1; md_release_at = -1; md_rose_at = 0;
        e_grant = '0; e_done = '0; e_err = '0; e_mgo = 1'b0; e_busy = 1'b0; e_data = '0;
    endtask

    task automatic model_step(input longint k);
        bit ended;
        e_done = '0;
        e_err  = '0;
        if (md_owner < 0) begin
            for (int s = NREQ; s >= 1; s--)
                if (bus.req[(md_last + s) % NREQ]) md_owner = (md_last + s) % NREQ;
            if (md_owner >= 0) begin
                md_last = md_owner; md_tries = 1;
                e_grant = '0; e_grant[md_owner] = 1'b1;
                e_data  = bus.req_data[24*md_owner +: 24];
                e_busy  = 1'b1;
                md_rise_at = k + 1; md_release_at = -1;
            end
        end else begin
            ended = e_mgo && (bus.mend || (TMO_EN && (k - md_rose_at == TIMEOUT_CYCLES)));
            if (ended) begin
                e_mgo = 1'b0;
                if (bus.mend && bus.mack) begin
                    e_done = e_grant; md_release_at = k + GAP_CYCLES;
                end else if (md_tries <= RETRY_MAX) begin
                    md_tries++; md_rise_at = k + GAP_CYCLES + 1;
                end else begin
                    e_err = e_grant; md_release_at = k + GAP_CYCLES;
                end
            end else if (k == md_rise_at) begin
                e_mgo = 1'b1; md_rose_at = k;
            end else if (k == md_release_at) begin
                e_grant = '0; e_busy = 1'b0; md_owner = -1;
            end
        end
    endtask

    // Observation history for the literal per-scenario checks.
    int          rises = 0;
    int          done_cnt [NREQ];
    int          err_cnt  [NREQ];
    logic [23:0] rise_data [$];
    int          gaps [$];
    int          hi_runs [$];
    logic [1:0]  grant_starts [$];

    initial begin
        longint          cyc = 0;
        logic            prev_mgo = 1'b0;
        logic [NREQ-1:0] prev_grant = '0;
        bit              have_fall = 1'b0;
        int              hi_run = 0, low_run = 0;
        for (int i = 0; i < NREQ; i++) begin done_cnt[i] = 0; err_cnt[i] = 0; end
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) begin
                model_reset(); have_fall = 1'b0; prev_mgo = 1'b0; prev_grant = '0;
            end
            check($sformatf("cycle%0d_outputs", cyc),
                  {bus.grant, bus.done, bus.err, bus.mgo, bus.busy, bus.i2c_data},
                  {e_grant, e_done, e_err, e_mgo, e_busy, e_data});
            if (bus.mgo && !prev_mgo) begin
                rises++; rise_data.push_back(bus.i2c_data);
                if (have_fall) gaps.push_back(low_run);
                hi_run = 0;
            end
            if (!bus.mgo && prev_mgo) begin
                hi_runs.push_back(hi_run); have_fall = 1'b1; low_run = 0;
            end
            if (bus.mgo) hi_run++; else low_run++;
            if (bus.grant != '0 && prev_grant == '0) grant_starts.push_back(bus.grant);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.done[i]) done_cnt[i]++;
                if (bus.err[i])  err_cnt[i]++;
            end
            prev_mgo = bus.mgo; prev_grant = bus.grant;
            if (reset) model_step(cyc + 1);
            cyc++;
        end
    end

    function automatic int get_cnt(input int which);
        case (which)
            0: return done_cnt[0];
            1: return done_cnt[1];
            2: return err_cnt[0];
            default: return err_cnt[1];
        endcase
    endfunction

    task automatic wait_cnt(input string name, input int which, input int target, input int budget);
        int n = 0;
        while (get_cnt(which) < target && n < budget) begin @(posedge clk); #1; n++; end
        if (get_cnt(which) < target) begin
            n_checks++;
            $display("FAIL %s: timed out after %0d cycles, count %0d, required %0d", name, n, get_cnt(which), target);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin @(posedge clk); #1; n++; end
        if (bus.busy) begin
            n_checks++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [23:0] data0, data1;
    task automatic set_data(input logic [23:0] d0, input logic [23:0] d1);
        data0 = d0; data1 = d1; bus.req_data = {data1, data0};
    endtask

    initial begin
        int b_rise, b_d0, b_d1, b_e0, b_e1, b_gs, b_gap, b_rd, b_hr, n, mingap;
        bit got;
        bus.req = '0;
        set_data(24'h0, 24'h0);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_mgo_busy", {30'd0, bus.mgo, bus.busy}, 32'h0);
        check("rst_i2c_data", 32'(bus.i2c_data), 32'h0);
        reset = 1'b1;

        // 1: single ACKed transfer, timing of mgo and release.
        set_data(24'h34001a, 24'h0); ack_mode = 1; dly = 20;
        @(posedge clk); #1 bus.req = 2'b01;
        @(posedge clk); #1;
        check("t1_grant_1clk", 32'(bus.grant), 32'h1);
        check("t1_mgo_low_1clk", 32'(bus.mgo), 32'h0);
        @(posedge clk); #1;
        check("t1_mgo_2clk", 32'(bus.mgo), 32'h1);
        check("t1_i2c_data", 32'(bus.i2c_data), 32'h34001a);
        got = 1'b0; n = 0;
        while (!got && n < 100) begin @(posedge clk); #1; n++; got = bus.done[0]; end
        check("t1_done_seen", 32'(got), 32'h1);
        bus.req = 2'b00;
        @(posedge clk); #1;
        check("t1_done_single", 32'(bus.done), 32'h0);
        repeat (2) @(posedge clk); #1;
        check("t1_busy_gap3", 32'(bus.busy), 32'h1);
        @(posedge clk); #1;
        check("t1_release_gap4", {30'd0, bus.grant == '0, bus.busy}, 32'h2);

        // 2: both requesters held, fair alternation.
        do_reset();
        set_data(24'h34021a, 24'h34047b); dly = 5;
        b_d0 = done_cnt[0]; b_d1 = done_cnt[1]; b_gs = grant_starts.size(); b_gap = gaps.size();
        bus.req = 2'b11;
        n = 0;
        while ((done_cnt[0] + done_cnt[1] - b_d0 - b_d1) < 4 && n < 400) begin @(posedge clk); #1; n++; end
        bus.req = 2'b00;
        wait_idle("t2_idle", 100);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_grant_seq%0d", i),
                  32'((grant_starts.size() > b_gs + i) ? grant_starts[b_gs + i] : 2'b00),
                  (i % 2 == 0) ? 32'h1 : 32'h2);
        check("t2_done0", 32'(done_cnt[0] - b_d0), 32'd2);
        check("t2_done1", 32'(done_cnt[1] - b_d1), 32'd2);
        mingap = 1000;
        for (int i = b_gap; i < gaps.size(); i++) if (gaps[i] < mingap) mingap = gaps[i];
        check("t2_min_gap_ge4", 32'(mingap >= GAP_CYCLES), 32'h1);

        // 3: permanent NACK exhausts retries.
        set_data(24'h3400ff, 24'h34047b); ack_mode = 0;
        b_rise = rises; b_d0 = done_cnt[0]; b_e0 = err_cnt[0]; b_rd = rise_data.size();
        bus.req = 2'b01;
        wait_cnt("t3_err_wait", 2, b_e0 + 1, 400);
        bus.req = 2'b00;
        wait_idle("t3_idle", 100);
        check("t3_mgo_pulses", 32'(rises - b_rise), 32'd4);
        for (int i = b_rd; i < rise_data.size(); i++)
            check($sformatf("t3_data_try%0d", i - b_rd), 32'(rise_data[i]), 32'h3400ff);
        check("t3_err0", 32'(err_cnt[0] - b_e0), 32'd1);
        check("t3_no_done", 32'(done_cnt[0] - b_d0), 32'd0);

        // 4: NACK then ACK for requester 1.
        att_base = att_total; ack_mode = 2;
        b_rise = rises; b_d1 = done_cnt[1]; b_e1 = err_cnt[1];
        bus.req = 2'b10;
        wait_cnt("t4_done_wait", 1, b_d1 + 1, 300);
        bus.req = 2'b00;
        wait_idle("t4_idle", 100);
        check("t4_mgo_pulses", 32'(rises - b_rise), 32'd2);
        check("t4_done1", 32'(done_cnt[1] - b_d1), 32'd1);
        check("t4_no_err", 32'(err_cnt[1] - b_e1), 32'd0);

        // 5: asynchronous reset in XFER.
        set_data(24'h345678, 24'h34047b); ack_mode = 1; dly = 40;
        b_d0 = done_cnt[0]; b_e0 = err_cnt[0];
        bus.req = 2'b01;
        n = 0;
        while (!bus.mgo && n < 20) begin @(posedge clk); #1; n++; end
        check("t5_in_xfer", 32'(bus.mgo), 32'h1);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t5_async_mgo_busy", {30'd0, bus.mgo, bus.busy}, 32'h0);
        check("t5_async_grant", 32'(bus.grant), 32'h0);
        check("t5_async_data", 32'(bus.i2c_data), 32'h0);
        bus.req = 2'b10; dly = 10;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("t5_grant_after_rst", 32'(bus.grant), 32'h2);
        wait_cnt("t5_done_wait", 1, done_cnt[1] + 1, 200);
        bus.req = 2'b00;
        wait_idle("t5_idle", 100);
        check("t5_abandoned", 32'((done_cnt[0] - b_d0) + (err_cnt[0] - b_e0)), 32'd0);

        // 6: master never answers.
        hang = 1'b1; ack_mode = 1; dly = 5;
        b_rise = rises; b_e0 = err_cnt[0]; b_d0 = done_cnt[0]; b_hr = hi_runs.size();
        set_data(24'h340a0a, 24'h34047b);
        bus.req = 2'b01;
`ifdef I2C_ARB_TIMEOUT_EN
        wait_cnt("t6_err_wait", 2, b_e0 + 1, 1000);
        bus.req = 2'b00;
        wait_idle("t6_idle", 100);
        check("t6_mgo_pulses", 32'(rises - b_rise), 32'd4);
        for (int i = b_hr; i < hi_runs.size(); i++)
            check($sformatf("t6_mgo_high_len%0d", i - b_hr), 32'(hi_runs[i]), 32'd100);
        check("t6_err0", 32'(err_cnt[0] - b_e0), 32'd1);
        check("t6_no_done", 32'(done_cnt[0] - b_d0), 32'd0);
        hang = 1'b0;
`else
        repeat (300) @(posedge clk); #1;
        check("t6_stuck_mgo_busy", {30'd0, bus.mgo, bus.busy}, 32'h3);
        check("t6_single_pulse", 32'(rises - b_rise), 32'd1);
        bus.req = 2'b00;
        hang = 1'b0;
        wait_cnt("t6_recover_done", 0, b_d0 + 1, 100);
        wait_idle("t6_idle", 100);
`endif
        repeat (3) @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares the single I2C write master (24-bit command, mgo/mend/mack handshake) between NREQ requesters, e.g. the boot-time audio codec register loader and runtime volume/mute control. Each requester submits one 24-bit command and receives a one-cycle done or err pulse. The block selects requesters round-robin, latches the command, drives the master, retries NACKed transfers, and enforces an idle gap between transactions.

Parameters:
NREQ, 2, number of requesters (2..8)
RETRY_MAX, 3, extra attempts after first NACK before err
GAP_CYCLES, 4, mgo-low cycles between transactions (>=1)
TIMEOUT_CYCLES, 1024, XFER watchdog limit; used only with I2C_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock (I2C control clock domain)
reset  in  1  asynchronous, active-low reset
req  in  NREQ  request, one bit per requester
req_data  in  24*NREQ  command for requester i at [24*i+23:24*i] ({dev addr, reg, data})
grant  out  NREQ  one-hot current owner
done  out  NREQ  one-cycle pulse: transfer ACKed
err  out  NREQ  one-cycle pulse: retries exhausted
busy  out  1  high whenever state != IDLE
mgo  out  1  go strobe to I2C master, level
i2c_data  out  24  latched command to I2C master
mend  in  1  master finished current transfer
mack  in  1  ACK status, valid when mend=1

Behaviour:
- Reset (async, reset=0): state IDLE; grant, done, err, mgo, busy = 0; i2c_data = 0; retry count = 0; round-robin pointer last = NREQ-1, so requester 0 wins first.
- FSM states: IDLE, LOAD, XFER, GAP.
- IDLE: if any req bit is set, search from last+1 with wrap-around modulo NREQ; the first set bit wins. Registered outputs: grant=onehot(winner), i2c_data=req_data slice of winner, last=winner, retry=0. Next state LOAD. No req: stay.
- LOAD: mgo<=1; next XFER. mgo therefore rises 2 clocks after the req sampled in IDLE.
- XFER: hold mgo=1 and i2c_data stable until mend=1, then mgo<=0 and:
  - mack=1: done[winner] pulse for 1 cycle; next GAP (final).
  - mack=0 and retry<RETRY_MAX: retry+1; next GAP (retry).
  - mack=0 and retry==RETRY_MAX: err[winner] pulse for 1 cycle; next GAP (final).
- GAP: count GAP_CYCLES with mgo=0.
  - Retry gap: next LOAD with the same i2c_data and grant.
  - Final gap: grant<=0; next IDLE.
- Total mgo pulses per transaction: at most RETRY_MAX+1.
- Requester contract: hold req until its done/err pulse. The arbiter samples req_data only in IDLE, so data may change after grant.
- req deasserted mid-transaction: ignored; the transaction completes and reports normally.
- req held after done/err: treated as a new request, re-arbitrated in the next IDLE. Persistent requests alternate fairly.
- done and err are mutually exclusive, and never occur for a requester that is not granted.
- Simultaneous new req and done in the same cycle: the new req waits for IDLE.
- mend while not in XFER: ignored.
- Reset mid-operation: all outputs clear immediately. The in-flight command is abandoned with no done/err. The I2C master is expected to share the same reset.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined: a counter runs in XFER. If mend has not arrived after TIMEOUT_CYCLES cycles, mgo<=0 and the event is treated exactly as mack=0 (retry or err).
- Undefined: no counter; XFER waits on mend indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
1. req[0]=1, req_data[23:0]=24'h34001a; master model asserts mend+mack 20 cycles after mgo -> mgo rises 2 cycles after req, i2c_data=34001a, done[0] single pulse, grant=0 and busy=0 after 4 gap cycles.
2. req=2'b11 held continuously with distinct data (34021a/34047b) -> grant sequence 01,10,01,10; each done pulse matches its owner; the mgo gap is always >=4 cycles.
3. mack always 0, RETRY_MAX=3 -> exactly 4 mgo pulses with identical i2c_data, then err[0] pulse, done never asserted.
4. First attempt NACK, second ACK -> 2 mgo pulses, done[1] once, err stays 0.
5. Async reset asserted mid-XFER -> mgo, grant, busy, i2c_data clear without a clock edge, no done/err. After release, req=2'b10 is served with requester 1 granted.
6. Macro defined, TIMEOUT_CYCLES=100, mend never asserted -> mgo drops after 100 cycles, 4 attempts, then err. Macro undefined -> busy remains 1 and mgo stays high.
